// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared state, opcode and ALU-select definitions for the processor control path
package proc_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_LOAD  = 4'd1,
    OP_STORE = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle Moore FSM sequencing PC, IR, data memory, register file and ALU
module control_unit
  import proc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  output logic        pc_clr,
  output logic        pc_up,
  output logic        im_rd,
  output logic        ir_ld,
  output logic [7:0]  d_addr,
  output logic        d_wr,
  output logic        rf_s,
  output logic [3:0]  rf_w_addr,
  output logic        rf_w_en,
  output logic [3:0]  rf_ra_addr,
  output logic [3:0]  rf_rb_addr,
  output logic [2:0]  alu_s0,
  output logic [3:0]  state,
  output logic        halted
);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] w_opcode;

  assign w_opcode = ir[15:12];
  assign state    = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Opcodes 6-15 fall through to NOOP; illegal state codes recover via INIT.
  always_comb begin
    w_next_state = ST_INIT;
    case (r_state)
      ST_INIT:   w_next_state = ST_FETCH;
      ST_FETCH:  w_next_state = ST_DECODE;
      ST_DECODE: begin
        case (w_opcode)
          OP_LOAD:  w_next_state = ST_LOAD_A;
          OP_STORE: w_next_state = ST_STORE;
          OP_ADD:   w_next_state = ST_ADD;
          OP_SUB:   w_next_state = ST_SUB;
          OP_HALT:  w_next_state = ST_HALT;
          default:  w_next_state = ST_NOOP;
        endcase
      end
      ST_NOOP:   w_next_state = ST_FETCH;
      ST_LOAD_A: w_next_state = ST_LOAD_B;
      ST_LOAD_B: w_next_state = ST_FETCH;
      ST_STORE:  w_next_state = ST_FETCH;
      ST_ADD:    w_next_state = ST_FETCH;
      ST_SUB:    w_next_state = ST_FETCH;
      ST_HALT:   w_next_state = ST_HALT;
      default:   w_next_state = ST_INIT;
    endcase
  end

  always_comb begin
    pc_clr     = 1'b0;
    pc_up      = 1'b0;
    im_rd      = 1'b0;
    ir_ld      = 1'b0;
    d_addr     = 8'h00;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = 4'h0;
    rf_w_en    = 1'b0;
    rf_ra_addr = 4'h0;
    rf_rb_addr = 4'h0;
    alu_s0     = ALU_PASS;
    halted     = 1'b0;
    case (r_state)
      ST_INIT: begin
        pc_clr = 1'b1;
      end
      ST_FETCH: begin
        im_rd = 1'b1;
        ir_ld = 1'b1;
        pc_up = 1'b1;
      end
      // LOAD_A only presents the address so the memory read settles before the write.
      ST_LOAD_A: begin
        d_addr    = ir[11:4];
        rf_w_addr = ir[3:0];
        rf_s      = 1'b1;
      end
      ST_LOAD_B: begin
        d_addr    = ir[11:4];
        rf_w_addr = ir[3:0];
        rf_s      = 1'b1;
        rf_w_en   = 1'b1;
      end
      ST_STORE: begin
        rf_ra_addr = ir[11:8];
        d_addr     = ir[7:0];
        d_wr       = 1'b1;
      end
      ST_ADD: begin
        rf_ra_addr = ir[11:8];
        rf_rb_addr = ir[7:4];
        rf_w_addr  = ir[3:0];
        alu_s0     = ALU_ADD;
        rf_w_en    = 1'b1;
      end
      ST_SUB: begin
        rf_ra_addr = ir[11:8];
        rf_rb_addr = ir[7:4];
        rf_w_addr  = ir[3:0];
        alu_s0     = ALU_SUB;
        rf_w_en    = 1'b1;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed and randomized-invariant bench for control_unit
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [15:0] ir;
  logic        pc_clr, pc_up, im_rd, ir_ld, d_wr, rf_s, rf_w_en, halted;
  logic [7:0]  d_addr;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state;
  logic [2:0]  alu_s0;

  int checks;
  int failures;

  control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .ir         (ir),
    .pc_clr     (pc_clr),
    .pc_up      (pc_up),
    .im_rd      (im_rd),
    .ir_ld      (ir_ld),
    .d_addr     (d_addr),
    .d_wr       (d_wr),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_w_en    (rf_w_en),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .alu_s0     (alu_s0),
    .state      (state),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // strobe vector {pc_clr, pc_up, im_rd, ir_ld, d_wr, rf_s, rf_w_en, halted}
  function automatic logic [7:0] strobes();
    return {pc_clr, pc_up, im_rd, ir_ld, d_wr, rf_s, rf_w_en, halted};
  endfunction

  function automatic logic [3:0] model_next(input logic [3:0] s, input logic [15:0] i, input logic r);
    if (r) return 4'd0;
    if (s == 4'd0) return 4'd1;
    if (s == 4'd1) return 4'd2;
    if (s == 4'd2) begin
      if (i[15:12] == 4'd1) return 4'd4;
      if (i[15:12] == 4'd2) return 4'd6;
      if (i[15:12] == 4'd3) return 4'd7;
      if (i[15:12] == 4'd4) return 4'd8;
      if (i[15:12] == 4'd5) return 4'd9;
      return 4'd3;
    end
    if (s == 4'd4) return 4'd5;
    if (s == 4'd9) return 4'd9;
    return 4'd1;
  endfunction

  initial begin
    logic [3:0] exp_state;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    ir       = 16'h3123;

    step();
    check("rst_state", state, 32'd0);
    check("rst_strobes", strobes(), 32'h80);
    check("rst_d_addr", d_addr, 32'h0);
    reset = 1'b0;

    // ADD 3123
    step();
    check("add_fetch_state", state, 32'd1);
    check("add_fetch_strobes", strobes(), 32'h70);
    step();
    check("add_decode_state", state, 32'd2);
    check("add_decode_strobes", strobes(), 32'h00);
    step();
    check("add_state", state, 32'd7);
    check("add_addrs", {rf_ra_addr, rf_rb_addr, rf_w_addr}, 32'h123);
    check("add_alu", alu_s0, 32'd1);
    check("add_strobes", strobes(), 32'h02);
    step();
    check("add_back_fetch", state, 32'd1);

    // LOAD 11A5
    ir = 16'h11A5;
    step();
    check("ld_decode", state, 32'd2);
    step();
    check("ld_a_state", state, 32'd4);
    check("ld_a_d_addr", d_addr, 32'h1A);
    check("ld_a_w_addr", rf_w_addr, 32'h5);
    check("ld_a_strobes", strobes(), 32'h04);
    step();
    check("ld_b_state", state, 32'd5);
    check("ld_b_d_addr", d_addr, 32'h1A);
    check("ld_b_w_addr", rf_w_addr, 32'h5);
    check("ld_b_strobes", strobes(), 32'h06);
    step();
    check("ld_back_fetch", state, 32'd1);

    // STORE 27C4
    ir = 16'h27C4;
    step();
    step();
    check("st_state", state, 32'd6);
    check("st_d_addr", d_addr, 32'hC4);
    check("st_ra", rf_ra_addr, 32'h7);
    check("st_strobes", strobes(), 32'h08);
    step();
    check("st_back_fetch", state, 32'd1);

    // SUB 4FE0
    ir = 16'h4FE0;
    step();
    step();
    check("sub_state", state, 32'd8);
    check("sub_addrs", {rf_ra_addr, rf_rb_addr, rf_w_addr}, 32'hFE0);
    check("sub_alu", alu_s0, 32'd2);
    check("sub_strobes", strobes(), 32'h02);
    step();
    check("sub_back_fetch", state, 32'd1);

    // undefined B000 behaves as NOOP: 3 cycles
    ir = 16'hB000;
    step();
    step();
    check("undef_state", state, 32'd3);
    check("undef_strobes", strobes(), 32'h00);
    check("undef_alu", alu_s0, 32'd0);
    step();
    check("undef_back_fetch", state, 32'd1);

    // HALT 5000 held for 20 cycles
    ir = 16'h5000;
    step();
    for (int k = 0; k < 20; k++) begin
      step();
      check("halt_state", state, 32'd9);
      check("halt_strobes", strobes(), 32'h01);
      check("halt_d_addr", d_addr, 32'h0);
    end
    reset = 1'b1;
    step();
    check("halt_reset_state", state, 32'd0);
    check("halt_reset_strobes", strobes(), 32'h80);
    reset = 1'b0;
    step();
    check("halt_reset_fetch", state, 32'd1);

    // reset asserted in LOAD_A: no rf_w_en pulse
    ir = 16'h11A5;
    step();
    step();
    check("ldrst_a_state", state, 32'd4);
    reset = 1'b1;
    step();
    check("ldrst_state", state, 32'd0);
    check("ldrst_wen", rf_w_en, 32'd0);
    reset = 1'b0;
    step();
    check("ldrst_wen_fetch", rf_w_en, 32'd0);
    check("ldrst_fetch", state, 32'd1);

    // random ir with occasional reset; model tracks state, invariants checked each cycle
    exp_state = 4'd1;
    for (int n = 0; n < 500; n++) begin
      ir    = 16'($urandom);
      reset = ($urandom_range(0, 29) == 0);
      exp_state = model_next(exp_state, ir, reset);
      step();
      check("rnd_state", state, {28'd0, exp_state});
      check("rnd_pc_excl", pc_up & pc_clr, 32'd0);
      check("rnd_wr_excl", d_wr & rf_w_en, 32'd0);
      check("rnd_ir_ld", ir_ld, {31'd0, exp_state == 4'd1});
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle Moore FSM that sequences the processor datapath.
- Drives the PC (clear/increment), instruction ROM read, IR load, data memory, register file and ALU select.
- Decodes the 16-bit instruction held in the instruction register.
- Sits between the IR output and every datapath control input; the top level exposes its state for board debug display.

Parameters:
- None. The instruction format is fixed: 16 bits, opcode in [15:12].

Ports:
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- ir  in  16  current instruction from the instruction register
- pc_clr  out  1  clear program counter to 0
- pc_up  out  1  increment program counter
- im_rd  out  1  instruction ROM read enable
- ir_ld  out  1  instruction register load enable
- d_addr  out  8  data memory address
- d_wr  out  1  data memory write enable
- rf_s  out  1  register-file write mux select: 1 = data memory, 0 = ALU
- rf_w_addr  out  4  register-file write address
- rf_w_en  out  1  register-file write enable
- rf_ra_addr  out  4  register-file read port A address
- rf_rb_addr  out  4  register-file read port B address
- alu_s0  out  3  ALU function select: 0 = pass A, 1 = A+B, 2 = A-B
- state  out  4  encoded current state, for debug display
- halted  out  1  high while in HALT

Behaviour:
- Opcodes ir[15:12]: 0 NOOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 HALT. Opcodes 6-15 behave as NOOP.
- Field rules:
  - LOAD: d_addr = ir[11:4], rf_w_addr = ir[3:0].
  - STORE: rf_ra_addr = ir[11:8], d_addr = ir[7:0].
  - ADD/SUB: rf_ra_addr = ir[11:8], rf_rb_addr = ir[7:4], rf_w_addr = ir[3:0].
- States and codes: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- Outputs are a pure combinational function of state and ir. Any output not listed for a state is 0.
- Only the state register is clocked; reset forces state to INIT on the next posedge regardless of current state, including mid-LOAD and HALT.
- Outputs in the cycle after reset: pc_clr=1, all others 0, state=0.
- INIT: pc_clr=1. Next: FETCH.
- FETCH: im_rd=1, ir_ld=1, pc_up=1. IR captures the new instruction at the end of this cycle. Next: DECODE.
- DECODE: no strobes. Next state chosen from ir[15:12] (now valid): NOOP, LOAD_A, STORE, ADD, SUB or HALT.
- NOOP: no strobes. Next: FETCH.
- LOAD_A: d_addr and rf_w_addr driven, rf_s=1, rf_w_en=0. This cycle covers data memory read latency. Next: LOAD_B.
- LOAD_B: same as LOAD_A plus rf_w_en=1. Next: FETCH.
- STORE: d_addr and rf_ra_addr driven, d_wr=1. Next: FETCH.
- ADD: ra/rb/w addresses driven, alu_s0=1, rf_s=0, rf_w_en=1. Next: FETCH.
- SUB: as ADD with alu_s0=2. Next: FETCH.
- HALT: halted=1, no strobes, self-loop. Only reset exits.
- Instruction cycle counts, FETCH through last execute state:
  - NOOP, STORE, ADD, SUB, undefined: 3 cycles.
  - LOAD: 4 cycles.
- Invariants:
  - pc_up and pc_clr are never high together.
  - d_wr and rf_w_en are never high together.
  - ir_ld is high only in FETCH.
- Unreachable state codes 10-15 return to INIT on the next clock.

Decomposition:
- Shared package proc_pkg holds:
  - enum state_t (4-bit, codes above)
  - enum opcode_t (4-bit)
  - ALU select constants ALU_PASS=0, ALU_ADD=1, ALU_SUB=2
- No sub-module. The block is one state register plus next-state and output case statements.

Test Plan:
- Reset then ir=16'h3123 (ADD): cycle after reset pc_clr=1. Then FETCH with im_rd/ir_ld/pc_up=1, then DECODE, then ADD with rf_ra_addr=1, rf_rb_addr=2, rf_w_addr=3, alu_s0=1, rf_w_en=1. Then FETCH.
- ir=16'h11A5 (LOAD): LOAD_A shows d_addr=8'h1A, rf_w_addr=5, rf_s=1, rf_w_en=0. LOAD_B is identical with rf_w_en=1. Total 4 cycles FETCH to LOAD_B.
- ir=16'h27C4 (STORE) then ir=16'h4FE0 (SUB):
  - STORE: d_addr=8'hC4, rf_ra_addr=7, d_wr=1, rf_w_en=0.
  - SUB: rf_ra_addr=F, rf_rb_addr=E, rf_w_addr=0, alu_s0=2.
- ir=16'h5000 (HALT): halted=1, state=9 held for 20 cycles with all strobes 0. Reset asserted: state=0 next cycle, then FETCH.
- ir=16'hB000 (undefined): passes through NOOP (state=3), no strobes, back to FETCH after 3 cycles.
- Reset asserted during LOAD_A: next cycle state=0 and rf_w_en never pulses. Random ir over 500 cycles: invariants hold every cycle.
